// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Central stall/flush sequencer for a 5-stage RISC-V pipeline.
//            Combines load-use hazard detection, taken-branch flushing and a
//            freeze state machine for the multi-cycle data-memory handshake,
//            with a timeout watchdog that latches a sticky fault.
// Ports    : clk, rst_n                  - clock, async active-low reset
//            idex_memRead, idex_rd       - load in EX and its destination
//            ifid_rs1/rs2(_used)         - ID sources and their use flags
//            ex_branch_taken             - EX resolved a taken branch/jump
//            mem_req, mem_ready          - data-memory handshake
//            pc_write .. memwb_write     - pipeline register enables
//            ifid_flush, idex_flush      - bubble insertion controls
//            mem_fault                   - sticky watchdog fault (registered)
//            stall_cycles, flush_count   - performance counters
// Config   : PIPE_HAZARD_PERF_EN - when defined, builds the performance
//            counters; otherwise both counter ports are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 16,   // legal range 1..255
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             idex_memRead,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic             ifid_rs1_used,
  input  logic             ifid_rs2_used,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             memwb_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

  state_e     state_q;
  logic [7:0] wait_cnt_q;
  logic       mem_fault_q;

  logic       w_lu;
  logic       w_frz;
  logic       w_branch_apply;
  logic       w_lu_apply;

  // Load-use: x0 is hardwired zero and never a real dependency.
  assign w_lu = idex_memRead && (idex_rd != '0) &&
                ((ifid_rs1_used && (ifid_rs1 == idex_rd)) ||
                 (ifid_rs2_used && (ifid_rs2 == idex_rd)));

  always_comb begin
    w_frz = 1'b0;
    unique case (state_q)
      ST_RUN:   w_frz = mem_req && !mem_ready;
      ST_WAIT:  w_frz = !mem_ready;
      ST_FAULT: w_frz = 1'b1;
      default:  w_frz = 1'b1;
    endcase
  end

  // Freeze holds EX/ID, so a suppressed branch or load-use is simply
  // re-evaluated in the release cycle rather than needing to be remembered.
  assign w_branch_apply = !w_frz && ex_branch_taken;
  assign w_lu_apply     = !w_frz && !ex_branch_taken && w_lu;

  // Enables are forced low while reset is asserted so nothing advances.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_write  = 1'b0;
    exmem_write = 1'b0;
    memwb_write = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    if (rst_n && !w_frz) begin
      idex_write  = 1'b1;
      exmem_write = 1'b1;
      memwb_write = 1'b1;
      pc_write    = !w_lu_apply;
      ifid_write  = !w_lu_apply;
      ifid_flush  = w_branch_apply;
      idex_flush  = w_branch_apply || w_lu_apply;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 8'd0;
      mem_fault_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (mem_req && !mem_ready) begin
            state_q    <= ST_WAIT;
            wait_cnt_q <= 8'd1;
          end
        end
        ST_WAIT: begin
          if (mem_ready) begin
            state_q <= ST_RUN;
          end else if (wait_cnt_q == C_TIMEOUT) begin
            state_q     <= ST_FAULT;
            mem_fault_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        ST_FAULT: begin
          // Absorbing until reset; mem_ready is deliberately ignored.
          state_q     <= ST_FAULT;
          mem_fault_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_RUN;
          wait_cnt_q  <= 8'd0;
          mem_fault_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_fault = mem_fault_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q;
  logic [CNT_W-1:0] flush_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (w_frz || w_lu_apply) begin
        stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      end
      if (w_branch_apply) begin
        flush_count_q <= flush_count_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed self-checking bench for pipe_hazard_ctrl (TIMEOUT=4).
//            Counter expectations collapse to zero when PIPE_HAZARD_PERF_EN
//            is not defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
  localparam logic [6:0] C_NORM = 7'b11111_00;
  localparam logic [6:0] C_BR   = 7'b11111_11;
  localparam logic [6:0] C_LU   = 7'b00111_01;
  localparam logic [6:0] C_FRZ  = 7'b00000_00;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             idex_memRead;
  logic [REG_W-1:0] idex_rd;
  logic [REG_W-1:0] ifid_rs1;
  logic [REG_W-1:0] ifid_rs2;
  logic             ifid_rs1_used;
  logic             ifid_rs2_used;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_write, ifid_write, idex_write, exmem_write, memwb_write;
  logic             ifid_flush, idex_flush, mem_fault;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int n_checks = 0;
  int n_errors = 0;

  wire [6:0] w_ctrl = {pc_write, ifid_write, idex_write, exmem_write,
                       memwb_write, ifid_flush, idex_flush};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(REG_W), .TIMEOUT(4), .CNT_W(CNT_W)) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .idex_memRead    (idex_memRead),
    .idex_rd         (idex_rd),
    .ifid_rs1        (ifid_rs1),
    .ifid_rs2        (ifid_rs2),
    .ifid_rs1_used   (ifid_rs1_used),
    .ifid_rs2_used   (ifid_rs2_used),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .idex_write      (idex_write),
    .exmem_write     (exmem_write),
    .memwb_write     (memwb_write),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .mem_fault       (mem_fault),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] cexp(input logic [63:0] v);
`ifdef PIPE_HAZARD_PERF_EN
    return v;
`else
    return 64'd0 & v;
`endif
  endfunction

  task automatic idle();
    idex_memRead    = 1'b0;
    idex_rd         = '0;
    ifid_rs1        = '0;
    ifid_rs2        = '0;
    ifid_rs1_used   = 1'b0;
    ifid_rs2_used   = 1'b0;
    ex_branch_taken = 1'b0;
    mem_req         = 1'b0;
    mem_ready       = 1'b0;
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle mid-cycle, away from the edge.
  task automatic settle();
    #2;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    check("rst_ctrl", 64'(w_ctrl), 64'(C_FRZ));
    check("rst_fault", 64'(mem_fault), 64'd0);
    check("rst_stall", 64'(stall_cycles), 64'd0);
    check("rst_flush", 64'(flush_count), 64'd0);
    rst_n = 1'b1;
    step();

    // Idle RUN
    settle();
    check("idle_ctrl", 64'(w_ctrl), 64'(C_NORM));
    step();

    // Load-use on rs1
    idex_memRead = 1'b1; idex_rd = 5'd5; ifid_rs1 = 5'd5; ifid_rs1_used = 1'b1;
    settle();
    check("lu_ctrl", 64'(w_ctrl), 64'(C_LU));
    step();
    check("lu_stall_cnt", 64'(stall_cycles), cexp(64'd1));
    idle();

    // x0 never hazards
    idex_memRead = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs1_used = 1'b1;
    settle();
    check("x0_ctrl", 64'(w_ctrl), 64'(C_NORM));
    step();
    idle();

    // Unused rs2 never hazards; used rs2 does
    idex_memRead = 1'b1; idex_rd = 5'd7; ifid_rs2 = 5'd7; ifid_rs2_used = 1'b0;
    settle();
    check("rs2_unused_ctrl", 64'(w_ctrl), 64'(C_NORM));
    step();
    ifid_rs2_used = 1'b1;
    settle();
    check("rs2_used_ctrl", 64'(w_ctrl), 64'(C_LU));
    step();
    check("rs2_stall_cnt", 64'(stall_cycles), cexp(64'd2));

    // Branch beats load-use
    ex_branch_taken = 1'b1;
    settle();
    check("br_lu_ctrl", 64'(w_ctrl), 64'(C_BR));
    step();
    check("br_lu_flush_cnt", 64'(flush_count), cexp(64'd1));
    check("br_lu_stall_cnt", 64'(stall_cycles), cexp(64'd2));
    idle();

    // Memory wait: 3 frozen cycles, release on the 4th
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("memw_frz%0d", i), 64'(w_ctrl), 64'(C_FRZ));
      step();
    end
    mem_ready = 1'b1;
    settle();
    check("memw_release", 64'(w_ctrl), 64'(C_NORM));
    step();
    check("memw_stall_cnt", 64'(stall_cycles), cexp(64'd5));
    check("memw_fault", 64'(mem_fault), 64'd0);
    // Back in RUN: ready in the request cycle gives zero freeze
    mem_req = 1'b1; mem_ready = 1'b1;
    settle();
    check("memw_zero_frz", 64'(w_ctrl), 64'(C_NORM));
    step();
    idle();

    // Branch during freeze is applied in the release cycle
    mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      check($sformatf("brfrz_hold%0d", i), 64'(w_ctrl), 64'(C_FRZ));
      step();
    end
    mem_ready = 1'b1;
    settle();
    check("brfrz_release", 64'(w_ctrl), 64'(C_BR));
    step();
    check("brfrz_flush_cnt", 64'(flush_count), cexp(64'd2));
    check("brfrz_stall_cnt", 64'(stall_cycles), cexp(64'd7));
    idle();

    // Timeout: 1 + TIMEOUT = 5 frozen cycles, then sticky fault
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check($sformatf("to_frz%0d", i), 64'(w_ctrl), 64'(C_FRZ));
      check($sformatf("to_nofault%0d", i), 64'(mem_fault), 64'd0);
      step();
    end
    check("to_fault", 64'(mem_fault), 64'd1);
    mem_ready = 1'b1; mem_req = 1'b0;
    settle();
    check("fault_ignores_ready", 64'(w_ctrl), 64'(C_FRZ));
    step();
    check("fault_sticky", 64'(mem_fault), 64'd1);
    check("fault_stall_cnt", 64'(stall_cycles), cexp(64'd13));

    // Asynchronous reset mid-fault
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_fault", 64'(mem_fault), 64'd0);
    check("arst_ctrl", 64'(w_ctrl), 64'(C_FRZ));
    check("arst_stall", 64'(stall_cycles), 64'd0);
    idle();
    step();
    #2;
    rst_n = 1'b1;
    step();
    settle();
    check("post_rst_ctrl", 64'(w_ctrl), 64'(C_NORM));
    check("post_rst_fault", 64'(mem_fault), 64'd0);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives their write enables and flush controls. It combines three things: load-use hazard detection, taken-branch flushing, and a freeze state machine for the multi-cycle data-memory handshake with a timeout watchdog. Every pipeline-register enable and every PC enable in the core comes from this block.

## Interface
Parameters:
- `REG_W`, 5: register-index width.
- `TIMEOUT`, 16: maximum WAIT cycles before fault; legal range 1..255.
- `CNT_W`, 32: performance-counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `idex_memRead` in 1: instruction in EX is a load.
- `idex_rd` in REG_W: destination register of the instruction in EX.
- `ifid_rs1`, `ifid_rs2` in REG_W: source registers of the instruction in ID.
- `ifid_rs1_used`, `ifid_rs2_used` in 1: the ID instruction actually reads rs1 / rs2.
- `ex_branch_taken` in 1: EX resolved a taken branch or jump.
- `mem_req` in 1: MEM stage has an active data-memory access.
- `mem_ready` in 1: data memory completes the access this cycle.
- `pc_write`, `ifid_write`, `idex_write`, `exmem_write`, `memwb_write` out 1: register enables.
- `ifid_flush`, `idex_flush` out 1: load a bubble into IF/ID or ID/EX.
- `mem_fault` out 1: sticky watchdog fault.
- `stall_cycles`, `flush_count` out CNT_W: performance counters.

## Operation
- Load-use term: `lu = idex_memRead & (idex_rd != 0) & ((ifid_rs1_used & ifid_rs1 == idex_rd) | (ifid_rs2_used & ifid_rs2 == idex_rd))`. x0 never causes a hazard.
- Freeze term:
  - In RUN: `frz = mem_req & !mem_ready`.
  - In WAIT: `frz = !mem_ready`.
  - In FAULT: `frz = 1`.
- Output priority, highest first:
  1. Freeze: all five write enables 0, both flushes 0.
  2. Branch (`ex_branch_taken`): all write enables 1, `ifid_flush=1`, `idex_flush=1`.
  3. Load-use (`lu`): `pc_write=0`, `ifid_write=0`, `idex_flush=1`; all other enables 1.
  4. Otherwise: all write enables 1, flushes 0.
- Branch and load-use together: the branch wins. The dependent instruction is flushed, so no bubble is added.
- A branch or load-use arriving during a freeze is not lost. The EX and ID contents are held, so the condition is re-evaluated in the release cycle.
- State machine, 2-bit state plus an 8-bit `wait_cnt`:
  - RUN: if `mem_req & !mem_ready`, go to WAIT and set `wait_cnt←1`. Otherwise stay in RUN.
  - WAIT, `mem_ready=1`: go to RUN. Outputs in this cycle follow the RUN priority with `frz=0`.
  - WAIT, `mem_ready=0` and `wait_cnt==TIMEOUT`: go to FAULT.
  - WAIT, otherwise: `wait_cnt++`.
  - FAULT: absorbing until reset. `mem_ready` is ignored.
- `mem_fault` is 1 exactly when state is FAULT. It is a registered output.

## Timing
- Control outputs are combinational from registered state and current inputs, with zero latency. Stall and flush take effect on the same rising edge as the hazard.
- Load-use produces exactly a 1-cycle bubble when no freeze overlaps it.
- Freeze length when memory is late:
  - The request cycle plus N WAIT cycles, where `mem_ready` arrives in WAIT cycle N+1.
  - `mem_ready` in the request cycle itself gives zero freeze.
- Fault timing: with `mem_ready` never asserted, the pipeline is frozen for 1+TIMEOUT cycles. `mem_fault` rises on the following edge.
- Reset (`rst_n=0`), asynchronous:
  - state RUN, `wait_cnt=0`.
  - `mem_fault=0`, counters 0.
  - While reset is low, all write enables are forced to 0 and both flushes to 0.
- Reset during WAIT or FAULT returns to RUN immediately. The first cycle after release is normal RUN.

## Configuration
- Macro `PIPE_HAZARD_PERF_EN`.
- Defined:
  - `stall_cycles` increments in every cycle with freeze or load-use stall.
  - `flush_count` increments in every cycle where the branch flush is applied.
  - Both wrap modulo 2^CNT_W. Neither counts while `rst_n` is low.
- Undefined: both counter ports are tied to 0 and no counter flops are built. Ports remain so the interface is unchanged.

## Test plan
- Load-use: `idex_memRead=1`, `idex_rd=5`, `ifid_rs1=5`, `ifid_rs1_used=1` for one cycle → `pc_write=0`, `ifid_write=0`, `idex_flush=1` for that cycle; `stall_cycles` 0→1.
- x0 and unused source:
  - `idex_rd=0` with matching rs1 → no stall.
  - `ifid_rs2=7`, `idex_rd=7`, `ifid_rs2_used=0` → no stall.
- Branch plus load-use in the same cycle → `ifid_flush=1`, `idex_flush=1`, `pc_write=1`; `flush_count` +1; `stall_cycles` unchanged.
- Memory wait: `mem_req=1`, `mem_ready=0` for 3 cycles, then `mem_ready=1` → all write enables 0 for 3 cycles and 1 in the 4th; state back to RUN; `stall_cycles` = 3.
- Timeout: with `TIMEOUT=4`, `mem_req=1` and `mem_ready` held at 0 → 5 frozen cycles, then `mem_fault=1`. Later `mem_ready=1` leaves it frozen. Asserting `rst_n=0` mid-fault clears `mem_fault` asynchronously.
- Branch during freeze: `ex_branch_taken=1` held through a 2-cycle WAIT → flushes 0 while frozen; `ifid_flush=1` and `idex_flush=1` in the release cycle; `flush_count` +1.
